vvp_acc: RTL and testbench

- Pipelined, accumulating successor to the combinational vector-vector product.
- Each beat takes one N-lane product plane: 1-bit weight × 2-bit signed data per lane, under the 2-bit weight mode. The plane is reduced through a registered adder tree.
- The tree sum is shifted, optionally negated, and accumulated across beats.
- Multi-bit weight/data products are composed bit-serially from planes; the result is emitted once per vector (first..last beats).

---
 rtl/vvp_pkg.sv | 52 +++++
 rtl/vvp_tree_pipe.sv | 88 ++++++++
 rtl/vvp_acc.sv | 114 +++++++++++
 tb/tb_vvp_acc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vvp_pkg.sv
// Shared definitions for the accumulating vector-vector product:
// weight-mode encodings, the per-lane product and width/latency helpers.
package vvp_pkg;

    // Weight-mode encodings (meaning of a weight bit w in each mode)
    typedef enum logic [1:0] {
        VVP_MODE_PM1  = 2'b00,  // w ? -d : +d
        VVP_MODE_Z_P1 = 2'b01,  // w ? +d : 0
        VVP_MODE_Z_M1 = 2'b10,  // w ? -d : 0
        VVP_MODE_ZERO = 2'b11   // always 0
    } vvp_mode_e;

    // Lane product width: 3 bits so that -(-2) = +2 is representable
    localparam int VVP_PW = 3;

    // clog2 that returns 0 for a single lane
    function automatic int vvp_clog2(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Full tree sum width for n lanes
    function automatic int vvp_tw(input int n);
        return vvp_clog2(n) + VVP_PW;
    endfunction

    // Beat-to-result latency: product stage, tree levels, accumulate stage
    function automatic int vvp_lat(input int n);
        return vvp_clog2(n) + 2;
    endfunction

    // Signed product of one weight bit and one 2-bit signed data value
    function automatic logic signed [VVP_PW-1:0] vvp_lane_prod(
        input vvp_mode_e  mode,
        input logic       w,
        input logic [1:0] d
    );
        logic signed [VVP_PW-1:0] pos;
        logic signed [VVP_PW-1:0] neg;
        logic signed [VVP_PW-1:0] res;
        pos = signed'({d[1], d});
        neg = -pos;
        res = '0;
        case (mode)
            VVP_MODE_PM1:  res = w ? neg : pos;
            VVP_MODE_Z_P1: res = w ? pos : '0;
            VVP_MODE_Z_M1: res = w ? neg : '0;
            default:       res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vvp_tree_pipe.sv
// Registered signed adder tree: one register per pairwise-add level, with
// a sideband bus delayed in lockstep. Lanes are padded with zeros up to
// the next power of two; each level grows by one bit so nothing truncates.
module vvp_tree_pipe
    import vvp_pkg::*;
#(
    parameter int N   = 64,
    parameter int IW  = 3,
    parameter int SBW = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N*IW-1:0]                    in_data,
    input  logic [SBW-1:0]                     in_sb,
    output logic signed [IW+vvp_clog2(N)-1:0]  out_sum,
    output logic [SBW-1:0]                     out_sb
);

    localparam int A = vvp_clog2(N);
    localparam int P = 1 << A;

    // Bit offset of level l inside the flattened node bus
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int k = 0; k < l; k++) begin
            o += (P >> k) * (IW + k);
        end
        return o;
    endfunction

    localparam int FW = lvl_off(A + 1);

    // All tree levels, level 0 (the inputs) first, then each register level
    logic [FW-1:0]        flat;
    logic [(A+1)*SBW-1:0] sb_all;

    genvar gi, gj;

    for (gj = 0; gj < P; gj++) begin : g_leaf
        if (gj < N) begin : g_real
            assign flat[gj*IW +: IW] = in_data[gj*IW +: IW];
        end else begin : g_pad
            assign flat[gj*IW +: IW] = '0;
        end
    end
    assign sb_all[0 +: SBW] = in_sb;

    for (gi = 1; gi <= A; gi++) begin : g_lvl
        localparam int LW   = IW + gi;
        localparam int PLW  = LW - 1;
        localparam int CNT  = P >> gi;
        localparam int OFF  = lvl_off(gi);
        localparam int POFF = lvl_off(gi - 1);

        logic [CNT*LW-1:0] node_d, node_q;
        logic [SBW-1:0]    sb_d, sb_q;

        // Pairwise sign-extended adds of the previous level
        always_comb begin
            node_d = '0;
            for (int j = 0; j < CNT; j++) begin
                node_d[j*LW +: LW] =
                    LW'($signed(flat[POFF + (2*j)*PLW +: PLW])) +
                    LW'($signed(flat[POFF + (2*j+1)*PLW +: PLW]));
            end
            sb_d = sb_all[(gi-1)*SBW +: SBW];
        end

        // Level register; reset clears sideband valid so in-flight beats vanish
        always_ff @(posedge clk) begin
            if (rst) begin
                node_q <= '0;
                sb_q   <= '0;
            end else begin
                node_q <= node_d;
                sb_q   <= sb_d;
            end
        end

        assign flat[OFF +: CNT*LW]     = node_q;
        assign sb_all[gi*SBW +: SBW]   = sb_q;
    end

    assign out_sum = $signed(flat[lvl_off(A) +: IW + A]);
    assign out_sb  = sb_all[A*SBW +: SBW];

endmodule

// File: rtl/vvp_acc.sv
// Pipelined accumulating vector-vector product: registered lane products,
// registered adder tree, then shift / negate / accumulate per beat with a
// result pulse on the last beat of each vector.
module vvp_acc
    import vvp_pkg::*;
#(
    parameter int N    = 64,
    parameter int ACCW = 32,
    parameter int SHW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [1:0]        in_mode,
    input  logic [N-1:0]      in_w,
    input  logic [2*N-1:0]    in_d,
    input  logic [SHW-1:0]    in_shift,
    input  logic              in_neg,
    output logic              out_valid,
    output logic [ACCW-1:0]   out_sum
);

    localparam int TW  = vvp_tw(N);
    localparam int PW  = VVP_PW;
    localparam int SBW = SHW + 4;
    localparam int EW  = (ACCW > TW) ? ACCW : TW;

    logic [N*PW-1:0]       prod_d, prod_q;
    logic [SBW-1:0]        sb0_d, sb0_q;
    logic signed [TW-1:0]  tree_sum;
    logic [SBW-1:0]        tree_sb;

    // Stage 0 lane products and sideband packing {valid, first, last, neg, shift}
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < N; i++) begin
            prod_d[i*PW +: PW] = vvp_lane_prod(vvp_mode_e'(in_mode), in_w[i], in_d[2*i +: 2]);
        end
        sb0_d = {in_valid, in_first, in_last, in_neg, in_shift};
    end

    // Stage 0 register
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            sb0_q  <= '0;
        end else begin
            prod_q <= prod_d;
            sb0_q  <= sb0_d;
        end
    end

    vvp_tree_pipe #(
        .N   (N),
        .IW  (PW),
        .SBW (SBW)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .in_data (prod_q),
        .in_sb   (sb0_q),
        .out_sum (tree_sum),
        .out_sb  (tree_sb)
    );

    logic             t_valid, t_first, t_last, t_neg;
    logic [SHW-1:0]   t_shift;
    assign {t_valid, t_first, t_last, t_neg, t_shift} = tree_sb;

    logic [ACCW-1:0]  term;
    logic [ACCW-1:0]  acc_next;
    logic [ACCW-1:0]  acc_d, acc_q;
    logic [ACCW-1:0]  out_sum_d, out_sum_q;
    logic             out_valid_d, out_valid_q;

    // Beat term (sign-extend or wrap to ACCW, shift, optional negate) and accumulate
    always_comb begin
        term = ACCW'(EW'(tree_sum));
        term = term << t_shift;
        if (t_neg) begin
            term = -term;
        end
        acc_next    = (t_first ? '0 : acc_q) + term;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_valid_d = 1'b0;
        if (t_valid) begin
            acc_d = acc_next;
            if (t_last) begin
                out_sum_d   = acc_next;
                out_valid_d = 1'b1;
            end
        end
    end

    // Accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_vvp_acc.sv
// Bench for vvp_acc: directed vectors with fixed expected results, then
// random beats checked cycle by cycle against an arithmetic reference model.
module tb_vvp_acc;
    import vvp_pkg::*;

    localparam int N    = 64;
    localparam int ACCW = 32;
    localparam int SHW  = 5;
    localparam int LAT  = vvp_lat(N);
    localparam longint MASK = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, in_neg = 1'b0;
    logic [1:0]       in_mode  = '0;
    logic [N-1:0]     in_w     = '0;
    logic [2*N-1:0]   in_d     = '0;
    logic [SHW-1:0]   in_shift = '0;

    logic             ov_a, ov_b, ov_c;
    logic [31:0]      os_a;
    logic [7:0]       os_b;
    logic [31:0]      os_c;

    vvp_acc #(.N(N), .ACCW(ACCW), .SHW(SHW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_mode(in_mode), .in_w(in_w), .in_d(in_d), .in_shift(in_shift), .in_neg(in_neg),
        .out_valid(ov_a), .out_sum(os_a));

    vvp_acc #(.N(N), .ACCW(8), .SHW(SHW)) u_dut_a8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_mode(in_mode), .in_w(in_w), .in_d(in_d), .in_shift(in_shift), .in_neg(in_neg),
        .out_valid(ov_b), .out_sum(os_b));

    vvp_acc #(.N(1), .ACCW(32), .SHW(SHW)) u_dut_n1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_mode(in_mode), .in_w(in_w[0:0]), .in_d(in_d[1:0]), .in_shift(in_shift), .in_neg(in_neg),
        .out_valid(ov_c), .out_sum(os_c));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: sum of lane products straight from the mode table
    function automatic longint model_plane(input logic [1:0] mode, input logic [N-1:0] w,
                                           input logic [2*N-1:0] d);
        longint s;
        int     dv;
        s = 0;
        for (int i = 0; i < N; i++) begin
            dv = d[2*i+1] ? int'(d[2*i +: 2]) - 4 : int'(d[2*i +: 2]);
            case (mode)
                2'b00:   s += w[i] ? -dv : dv;
                2'b01:   s += w[i] ? dv : 0;
                2'b10:   s += w[i] ? -dv : 0;
                default: s += 0;
            endcase
        end
        return s;
    endfunction

    typedef struct { longint due; longint val; } exp_t;
    exp_t   exp_q[$];
    longint m_acc    = 0;
    longint edge_cnt = 0;
    bit     mon_en   = 1'b0;

    // Model: consume each accepted beat at the clock edge that samples it
    initial begin
        longint term;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (rst) begin
                m_acc = 0;
                exp_q.delete();
            end else if (in_valid) begin
                term = (model_plane(in_mode, in_w, in_d) <<< in_shift) & MASK;
                if (in_neg) term = (-term) & MASK;
                m_acc = ((in_first ? 64'd0 : m_acc) + term) & MASK;
                if (in_last) exp_q.push_back('{due: edge_cnt + LAT - 1, val: m_acc});
            end
        end
    end

    // Monitor: every cycle, out_valid must match the model's schedule
    initial begin
        bit expv;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                expv = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
                check_val("out_valid", longint'(ov_a), longint'(expv));
                if (expv) begin
                    check_val("out_sum", longint'(os_a), exp_q[0].val);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit v, input bit f, input bit l, input logic [1:0] m,
                         input logic [N-1:0] w, input logic [2*N-1:0] d,
                         input int sh, input bit ng);
        @(negedge clk);
        in_valid = v; in_first = f; in_last = l; in_mode = m;
        in_w = w; in_d = d; in_shift = SHW'(sh); in_neg = ng;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for the first result pulse of one DUT; check latency and value
    task automatic expect_out(input string tag, input int which, input longint exp, input int lat);
        int     cnt;
        bit     got;
        longint val;
        cnt = 0; got = 1'b0; val = 0;
        while (!got && cnt < 3 * LAT) begin
            @(negedge clk);
            in_valid = 1'b0;
            cnt++;
            case (which)
                0: if (ov_a) begin got = 1'b1; val = longint'($signed(os_a)); end
                1: if (ov_b) begin got = 1'b1; val = longint'($signed(os_b)); end
                default: if (ov_c) begin got = 1'b1; val = longint'($signed(os_c)); end
            endcase
        end
        check_val({tag, ".seen"}, longint'(got), 1);
        check_val({tag, ".lat"}, longint'(cnt), longint'(lat));
        check_val({tag, ".sum"}, val, exp);
    endtask

    logic [N-1:0]   w0, w1;
    logic [2*N-1:0] d_m1, d_m2, d_p1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        w0 = '0; w1 = '1;
        d_m1 = '1;
        d_m2 = {N{2'b10}};
        d_p1 = {N{2'b01}};

        repeat (3) @(negedge clk);
        check_val("rst.ov_a", longint'(ov_a), 0);
        check_val("rst.os_a", longint'(os_a), 0);
        check_val("rst.ov_b", longint'(ov_b), 0);
        check_val("rst.os_b", longint'(os_b), 0);
        check_val("rst.ov_c", longint'(ov_c), 0);
        check_val("rst.os_c", longint'(os_c), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single beat, all data -1, mode 00 with w=0 -> -64
        drive(1, 1, 1, 2'b00, w0, d_m1, 0, 0);
        expect_out("neg64", 0, -64, LAT);

        // -(-2) on every lane must not wrap -> +128
        drive(1, 1, 1, 2'b00, w1, d_m2, 0, 0);
        expect_out("pos128", 0, 128, LAT);

        // Three dense beats, shifts 0,1,2 -> 448; with last beat negated -> -64
        drive(1, 1, 0, 2'b01, w1, d_p1, 0, 0);
        drive(1, 0, 0, 2'b01, w1, d_p1, 1, 0);
        drive(1, 0, 1, 2'b01, w1, d_p1, 2, 0);
        expect_out("dense448", 0, 448, LAT);
        drive(1, 1, 0, 2'b01, w1, d_p1, 0, 0);
        drive(1, 0, 0, 2'b01, w1, d_p1, 1, 0);
        drive(1, 0, 1, 2'b01, w1, d_p1, 2, 1);
        expect_out("dense_neg", 0, -64, LAT);

        // Back-to-back single-beat vectors -> 64 then 0 on consecutive cycles
        drive(1, 1, 1, 2'b01, w1, d_p1, 0, 0);
        drive(1, 1, 1, 2'b11, w1, d_p1, 0, 0);
        expect_out("b2b_first", 0, 64, LAT - 1);
        @(negedge clk);
        check_val("b2b_second.valid", longint'(ov_a), 1);
        check_val("b2b_second.sum", longint'($signed(os_a)), 0);

        // Same three beats with idle gaps -> 448
        drive(1, 1, 0, 2'b01, w1, d_p1, 0, 0);
        idle(2);
        drive(1, 0, 0, 2'b01, w1, d_p1, 1, 0);
        idle(1);
        drive(1, 0, 1, 2'b01, w1, d_p1, 2, 0);
        expect_out("gaps448", 0, 448, LAT);

        // Reset two cycles after a first beat, then a fresh vector -> -64
        drive(1, 1, 0, 2'b01, w1, d_p1, 0, 0);
        idle(1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_mode = 2'b10;
        in_w = w1; in_d = d_p1; in_shift = '0; in_neg = 1'b0;
        expect_out("after_rst", 0, -64, LAT);

        // ACCW=8: 64 << 2 = 256 wraps to 0
        idle(LAT + 2);
        drive(1, 1, 1, 2'b01, w1, d_p1, 2, 0);
        expect_out("accw8_wrap", 1, 0, LAT);

        // N=1: mode 00, w=1, d=-2 -> +2 after two cycles
        idle(LAT + 2);
        drive(1, 1, 1, 2'b00, w1, d_m2, 0, 0);
        expect_out("n1_pos2", 2, 2, 2);
        idle(LAT + 2);

        // Random beats, occasional reset; the monitor checks every cycle
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_first = ($urandom_range(0, 3) == 0);
            in_last  = ($urandom_range(0, 3) == 0);
            in_mode  = 2'($urandom_range(0, 3));
            in_w     = {$urandom, $urandom};
            in_d     = {$urandom, $urandom, $urandom, $urandom};
            in_shift = SHW'($urandom_range(0, 31));
            in_neg   = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        idle(LAT + 4);
        check_val("drain", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
